// File: rtl/i2c_master_pkg.sv
// Shared definitions for the byte-level I2C master: command encodings,
// controller states and counter widths.
package i2c_master_pkg;

    localparam int QCNT_W = 16;  // quarter-period counter width
    localparam int BCNT_W = 4;   // bit counter width, counts 0..8

    typedef enum logic [1:0] {
        CMD_START = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_STOP  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WR_BIT,
        ST_WR_ACK,
        ST_RD_BIT,
        ST_RD_ACK,
        ST_STOP,
        ST_DONE
    } state_e;

endpackage

// File: rtl/i2c_scl_tick_gen.sv
// Quarter-SCL-period tick generator. The counter reloads with QUARTER_DIV-1
// and ticks when it reaches zero. While hold_i is high the counter stays at
// reload, so a stretched SCL delays the quarter by exactly the stretch time.
module i2c_scl_tick_gen
    import i2c_master_pkg::*;
#(
    parameter int QUARTER_DIV = 250
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic restart_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam logic [QCNT_W-1:0] RELOAD = QCNT_W'(QUARTER_DIV - 1);

    logic [QCNT_W-1:0] cnt_q;
    logic [QCNT_W-1:0] cnt_d;

    assign tick_o = en_i & ~hold_i & ~restart_i & (cnt_q == '0);

    // Next count: reload on restart, disable, hold or terminal count.
    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (restart_i || !en_i || hold_i || tick_o) begin
            cnt_d = RELOAD;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_master_controller.sv
// Byte-level I2C master. Converts START/WRITE/READ/STOP commands into
// open-drain SCL/SDA drive (oe=1 pulls the line low).
// Optional build macro: I2C_MASTER_CLK_STRETCH_EN enables clock stretching
// (quarter counter holds while a released SCL is still seen low).
//
// state     | meaning
// ST_IDLE   | waiting for a command; SCL held low while the bus is owned
// ST_START  | 4-quarter (repeated) START condition
// ST_WR_BIT | shifting out one of 8 data bits, MSB first
// ST_WR_ACK | 9th bit of a WRITE, SDA released, slave ACK sampled
// ST_RD_BIT | shifting in one of 8 data bits, MSB first
// ST_RD_ACK | 9th bit of a READ, master drives ACK/NACK
// ST_STOP   | 4-quarter STOP condition
// ST_DONE   | one-cycle completion pulse; accepts a new command like IDLE
module i2c_master_controller
    import i2c_master_pkg::*;
#(
    parameter int QUARTER_DIV = 250
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_i,
    input  logic [7:0] tx_data_i,
    input  logic       rd_last_i,
    output logic       done_o,
    output logic       err_o,
    output logic       ack_rcvd_o,
    output logic [7:0] rx_data_o,
    output logic       busy_o,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe_o,
    output logic       sda_oe_o
);

    state_e            state_q, state_d;
    logic [1:0]        qtr_q, qtr_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              rd_last_q, rd_last_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              ack_q, ack_d;
    logic [7:0]        rx_q, rx_d;

    logic active;
    logic accept;
    logic tick;
    logic hold;

    assign active      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign cmd_ready_o = ~active;
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = err_q;
    assign ack_rcvd_o  = ack_q;
    assign rx_data_o   = rx_q;
    assign busy_o      = busy_q;

`ifdef I2C_MASTER_CLK_STRETCH_EN
    // A released SCL that still reads low is a slave stretching the clock.
    assign hold = active & ~scl_oe_o & ~scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold       = 1'b0;
`endif

    i2c_scl_tick_gen #(
        .QUARTER_DIV(QUARTER_DIV)
    ) u_tick (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (active),
        .restart_i(accept),
        .hold_i   (hold),
        .tick_o   (tick)
    );

    // Line drive decoded from the current state and quarter.
    always_comb begin
        scl_oe_o = 1'b0;
        sda_oe_o = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: scl_oe_o = busy_q;
            ST_START: begin
                unique case (qtr_q)
                    2'd0: scl_oe_o = busy_q;
                    2'd1: ;
                    2'd2: sda_oe_o = 1'b1;
                    2'd3: begin
                        scl_oe_o = 1'b1;
                        sda_oe_o = 1'b1;
                    end
                endcase
            end
            ST_WR_BIT: begin
                scl_oe_o = ~qtr_q[1];
                sda_oe_o = ~shift_q[7];
            end
            ST_WR_ACK, ST_RD_BIT: scl_oe_o = ~qtr_q[1];
            ST_RD_ACK: begin
                scl_oe_o = ~qtr_q[1];
                sda_oe_o = ~rd_last_q;
            end
            ST_STOP: begin
                scl_oe_o = (qtr_q == 2'd0);
                sda_oe_o = ~qtr_q[1];
            end
        endcase
    end

    // Next-state, shift register and status updates.
    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        rd_last_d = rd_last_q;
        busy_d    = busy_q;
        err_d     = err_q;
        ack_d     = ack_q;
        rx_d      = rx_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    err_d  = 1'b0;
                    qtr_d  = '0;
                    bcnt_d = '0;
                    unique case (cmd_e'(cmd_i))
                        CMD_START: state_d = ST_START;
                        CMD_WRITE: begin
                            if (busy_q) begin
                                state_d = ST_WR_BIT;
                                shift_d = tx_data_i;
                            end else begin
                                state_d = ST_DONE;
                                err_d   = 1'b1;
                            end
                        end
                        CMD_READ: begin
                            if (busy_q) begin
                                state_d   = ST_RD_BIT;
                                rd_last_d = rd_last_i;
                            end else begin
                                state_d = ST_DONE;
                                err_d   = 1'b1;
                            end
                        end
                        CMD_STOP: state_d = busy_q ? ST_STOP : ST_DONE;
                    endcase
                end
            end
            default: begin
                if (tick) begin
                    qtr_d = qtr_q + 1'b1;
                    unique case (state_q)
                        ST_START: begin
                            if (qtr_q == 2'd3) begin
                                busy_d  = 1'b1;
                                state_d = ST_DONE;
                            end
                        end
                        ST_WR_BIT: begin
                            if (qtr_q == 2'd3) begin
                                shift_d = {shift_q[6:0], 1'b0};
                                bcnt_d  = bcnt_q + 1'b1;
                                if (bcnt_q == BCNT_W'(7)) state_d = ST_WR_ACK;
                            end
                        end
                        ST_WR_ACK: begin
                            if (qtr_q == 2'd2) ack_d = ~sda_i;
                            if (qtr_q == 2'd3) state_d = ST_DONE;
                        end
                        ST_RD_BIT: begin
                            if (qtr_q == 2'd2) shift_d = {shift_q[6:0], sda_i};
                            if (qtr_q == 2'd3) begin
                                bcnt_d = bcnt_q + 1'b1;
                                if (bcnt_q == BCNT_W'(7)) state_d = ST_RD_ACK;
                            end
                        end
                        ST_RD_ACK: begin
                            if (qtr_q == 2'd3) begin
                                rx_d    = shift_q;
                                state_d = ST_DONE;
                            end
                        end
                        ST_STOP: begin
                            if (qtr_q == 2'd3) begin
                                busy_d  = 1'b0;
                                state_d = ST_DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts without issuing a STOP.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            qtr_q     <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            rd_last_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
            rx_q      <= '0;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            rd_last_q <= rd_last_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            ack_q     <= ack_d;
            rx_q      <= rx_d;
        end
    end

endmodule
